// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_dma_fifo_pkg
// Brief    : Shared state encodings and helpers for the DAC DMA elastic FIFO.
// Revision : 1.0
// ============================================================================
package ad_ip_jesd204_tpl_dac_dma_fifo_pkg;

    localparam int DUNF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } fifo_state_t;

    function automatic logic [DUNF_CNT_W-1:0] sat_inc(input logic [DUNF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_fifo_mem
// Brief    : Simple dual-port RAM, registered read with synchronous output clear.
// Revision : 1.0
// ============================================================================
module ad_ip_jesd204_tpl_dac_fifo_mem #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic                  rstb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_doutb;

    always_ff @(posedge clk) begin
        if (wea) begin
            r_mem[addra] <= dina;
        end
    end

    // Clear wins over a read so starved or idle cycles always present zero.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_doutb <= '0;
        end else if (enb) begin
            r_doutb <= r_mem[addrb];
        end
    end

    assign doutb = r_doutb;

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_dma_fifo
// Brief    : Prefilling elastic FIFO between DMA stream and TPL DAC samples.
// Revision : 1.0
// ============================================================================
module ad_ip_jesd204_tpl_dac_dma_fifo
    import ad_ip_jesd204_tpl_dac_dma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_enable,
    input  logic [ADDR_WIDTH:0]   cfg_prefill,
    input  logic                  cfg_rearm,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  dac_valid,
    output logic [DATA_WIDTH-1:0] dac_ddata,
    output logic                  dac_dunf,
    output logic [DUNF_CNT_W-1:0] dac_dunf_count,
    output logic [ADDR_WIDTH:0]   fifo_level
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    fifo_state_t             r_state;
    fifo_state_t             w_state_nxt;
    logic [ADDR_WIDTH:0]     r_wr_ptr;
    logic [ADDR_WIDTH:0]     r_rd_ptr;
    logic [ADDR_WIDTH:0]     w_wr_nxt;
    logic [ADDR_WIDTH:0]     w_rd_nxt;
    logic [ADDR_WIDTH:0]     w_level;
    logic [ADDR_WIDTH:0]     w_level_nxt;
    logic [ADDR_WIDTH:0]     w_prefill_eff;
    logic                    r_ready;
    logic                    r_dunf;
    logic [DUNF_CNT_W-1:0]   r_dunf_count;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_req;
    logic                    w_pop;
    logic                    w_unf;
    logic                    w_mem_clr;

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                           (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_level       = r_wr_ptr - r_rd_ptr;
    assign w_prefill_eff = (cfg_prefill > c_DEPTH) ? c_DEPTH : cfg_prefill;

    assign w_push = s_axis_valid & r_ready & ~w_full;
    assign w_req  = (r_state == ST_RUN) & dac_valid & fifo_enable;
    assign w_pop  = w_req & ~w_empty;
    assign w_unf  = w_req & w_empty;

    always_comb begin
        w_state_nxt = r_state;
        if (!fifo_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_PREFILL;
                ST_PREFILL: if (w_level >= w_prefill_eff) w_state_nxt = ST_RUN;
                ST_RUN:     if (w_unf && cfg_rearm) w_state_nxt = ST_PREFILL;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Disabling flushes by zeroing both pointers in the same edge.
    always_comb begin
        w_wr_nxt    = '0;
        w_rd_nxt    = '0;
        if (fifo_enable) begin
            w_wr_nxt = r_wr_ptr + (ADDR_WIDTH+1)'(w_push);
            w_rd_nxt = r_rd_ptr + (ADDR_WIDTH+1)'(w_pop);
        end
        w_level_nxt = w_wr_nxt - w_rd_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ready      <= 1'b0;
            r_dunf       <= 1'b0;
            r_dunf_count <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_ready  <= (w_state_nxt != ST_IDLE) && (w_level_nxt < c_DEPTH);
            r_dunf   <= w_unf;
            if (w_unf && !(&r_dunf_count)) begin
                r_dunf_count <= sat_inc(r_dunf_count);
            end
        end
    end

    assign w_mem_clr = reset | ~fifo_enable | (r_state != ST_RUN) | w_unf;

    ad_ip_jesd204_tpl_dac_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .wea   (w_push),
        .addra (r_wr_ptr[ADDR_WIDTH-1:0]),
        .dina  (s_axis_data),
        .enb   (w_pop),
        .rstb  (w_mem_clr),
        .addrb (r_rd_ptr[ADDR_WIDTH-1:0]),
        .doutb (dac_ddata)
    );

    assign s_axis_ready   = r_ready;
    assign dac_dunf       = r_dunf;
    assign dac_dunf_count = r_dunf_count;
    assign fifo_level     = w_level;

endmodule
`default_nettype wire
